// File: rtl/lsu_controller.sv
// Load/store sequencer between execute and the data-memory port: alignment checks,
// req/ack handshake with byte enables, pipeline stall, load extension and fault reporting.
module lsu_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0]  CAUSE_ILLEGAL  = 2'b00;
    localparam logic [1:0]  CAUSE_LD_ALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_ST_ALIGN = 2'b10;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         f3_q, f3_d;
    logic [4:0]         rd_q, rd_d;
    logic               wb_valid_q, wb_valid_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_cause_q, fault_cause_d;
    logic [31:0]        fault_addr_q, fault_addr_d;

    logic               launch;
    logic               is_load;
    logic               illegal;
    logic               misaligned;
    logic [3:0]         launch_be;
    logic [31:0]        launch_wdata;
    logic [31:0]        rdata_shift;
    logic [31:0]        load_ext;

    // Launch decode: a load wins if both read and write are flagged
    always_comb begin
        launch     = ex_valid && (ex_mem_read || ex_mem_write);
        is_load    = ex_mem_read;
        illegal    = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11) ||
                     (!is_load && ex_funct3[2]);
        misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                     ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
        case (ex_funct3[1:0])
            2'b00: begin
                launch_be    = 4'b0001 << ex_addr[1:0];
                launch_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                launch_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                launch_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                launch_be    = 4'b1111;
                launch_wdata = ex_wdata;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        rdata_shift = dmem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
            3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

    assign stall = ((state_q == ST_IDLE) && launch) || (state_q == ST_WAIT);

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        lane_d        = lane_q;
        f3_d          = f3_q;
        rd_d          = rd_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    if (illegal) begin
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_ILLEGAL;
                        fault_addr_d  = ex_addr;
                        state_d       = ST_DONE;
                    end else if (misaligned) begin
                        fault_d       = 1'b1;
                        fault_cause_d = is_load ? CAUSE_LD_ALIGN : CAUSE_ST_ALIGN;
                        fault_addr_d  = ex_addr;
                        state_d       = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = !is_load;
                        addr_d  = {ex_addr[31:2], 2'b00};
                        be_d    = launch_be;
                        wdata_d = launch_wdata;
                        lane_d  = ex_addr[1:0];
                        f3_d    = ex_funct3;
                        rd_d    = ex_rd;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_ext;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d         = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                    fault_addr_d  = {addr_q[31:2], lane_q};
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            lane_q        <= '0;
            f3_q          <= '0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= '0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            lane_q        <= lane_d;
            f3_q          <= f3_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: transaction-level expectation model plus a
// per-cycle compare process on the falling edge.
module tb_lsu_controller;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr;
    logic [1:0]  fault_cause;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    lsu_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    logic chk_en = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_wb_valid, exp_fault;
    logic [31:0] exp_addr, exp_wdata, exp_wb_data, exp_fault_addr;
    logic [3:0]  exp_be;
    logic [4:0]  exp_wb_rd;
    logic [1:0]  exp_fault_cause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes
    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (b >= int'(lane) && b < int'(lane) + sz(f3)) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(b % sz(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] rdata);
        logic [31:0] v, mask;
        int n;
        v = rdata >> (8 * int'(lane));
        n = 8 * sz(f3);
        if (n < 32) begin
            mask = (32'h1 << n) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // {faulted, cause}
    function automatic logic [2:0] m_fault(input logic ld, input logic [2:0] f3,
                                           input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (!ld && f3 >= 3'd4)) return 3'b100;
        if ((int'(addr[1:0]) % sz(f3)) != 0) return ld ? 3'b101 : 3'b110;
        return 3'b000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
            chk("fault", 32'(fault), 32'(exp_fault));
            chk("fault_cause", 32'(fault_cause), 32'(exp_fault_cause));
            chk("fault_addr", fault_addr, exp_fault_addr);
            if (exp_req) begin
                chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (exp_wb_valid) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
                chk("wb_data", wb_data, exp_wb_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        exp_stall    = 1'b0;
        exp_req      = 1'b0;
        exp_wb_valid = 1'b0;
        exp_fault    = 1'b0;
    endtask

    task automatic set_wait(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
        quiet();
        exp_stall = 1'b1;
        exp_req   = 1'b1;
        exp_we    = !ld;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = m_be(f3, addr[1:0]);
        exp_wdata = m_wdata(f3, wdata);
    endtask

    // One full access; ack_dly = WAIT cycle index of the ack, -1 for never
    task automatic run_mem(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input int ack_dly, input logic [31:0] rdata);
        logic       ld, acked;
        logic [2:0] flt;
        ld  = rd_en;
        flt = m_fault(ld, f3, addr);
        ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        quiet();
        exp_stall = 1'b1;
        step();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        if (flt[2]) begin
            quiet();
            exp_fault       = 1'b1;
            exp_fault_cause = flt[1:0];
            exp_fault_addr  = addr;
            step();
            quiet();
            step();
            return;
        end
        acked = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            set_wait(ld, f3, addr, wdata);
            dmem_ack   = (k == ack_dly);
            dmem_rdata = rdata;
            step();
            dmem_ack = 1'b0;
            if (k == ack_dly) begin
                acked = 1'b1;
                break;
            end
        end
        quiet();
        if (acked) begin
            exp_wb_valid = ld;
            exp_wb_rd    = rd;
            exp_wb_data  = m_ext(f3, addr[1:0], rdata);
        end else begin
            exp_fault       = 1'b1;
            exp_fault_cause = 2'b11;
            exp_fault_addr  = addr;
            dmem_ack        = 1'b1;
        end
        step();
        quiet();
        step();
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        quiet();
        exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
        exp_wb_rd = '0; exp_wb_data = '0;
        exp_fault_cause = '0; exp_fault_addr = '0;

        // Hand-computed values that pin the model
        chk("pin_be_lb3",   32'(m_be(3'b000, 2'd3)), 32'h8);
        chk("pin_be_sb1",   32'(m_be(3'b000, 2'd1)), 32'h2);
        chk("pin_be_lh2",   32'(m_be(3'b001, 2'd2)), 32'hC);
        chk("pin_be_lw",    32'(m_be(3'b010, 2'd0)), 32'hF);
        chk("pin_ext_lb",   m_ext(3'b000, 2'd3, 32'h80123456), 32'hFFFFFF80);
        chk("pin_ext_lbu",  m_ext(3'b100, 2'd3, 32'h80123456), 32'h00000080);
        chk("pin_ext_lh",   m_ext(3'b001, 2'd2, 32'h80011234), 32'hFFFF8001);
        chk("pin_wd_sb",    m_wdata(3'b000, 32'h12345678), 32'h78787878);
        chk("pin_wd_sh",    m_wdata(3'b001, 32'hABCD1234), 32'h12341234);
        chk("pin_flt_lw",   32'(m_fault(1'b1, 3'b010, 32'h102)), 32'h5);
        chk("pin_flt_sh",   32'(m_fault(1'b0, 3'b001, 32'h3)), 32'h6);
        chk("pin_flt_f3",   32'(m_fault(1'b1, 3'b011, 32'h0)), 32'h4);

        step();
        chk_en = 1'b1;
        step();
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_be", 32'(dmem_be), 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        rst = 1'b0;
        step();

        run_mem(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
        run_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 32'h80123456);
        run_mem(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 32'h80123456);
        run_mem(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 0, 32'h80011234);
        run_mem(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 5'd9, 2, 32'h80011234);
        run_mem(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 5'd0, 2, 32'h0);
        run_mem(1'b0, 1'b1, 3'b001, 32'h002, 32'hABCD1234, 5'd0, 0, 32'h0);
        run_mem(1'b0, 1'b1, 3'b010, 32'h040, 32'hCAFEF00D, 5'd0, 1, 32'h0);
        run_mem(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd3, 0, 32'h0);
        chk("lit_fault_addr", fault_addr, 32'h102);
        chk("lit_fault_cause", 32'(fault_cause), 32'h1);
        run_mem(1'b0, 1'b1, 3'b001, 32'h003, 32'h0, 5'd0, 0, 32'h0);
        run_mem(1'b1, 1'b0, 3'b011, 32'h008, 32'h0, 5'd4, 0, 32'h0);
        run_mem(1'b0, 1'b1, 3'b100, 32'h010, 32'h0, 5'd0, 0, 32'h0);
        run_mem(1'b1, 1'b1, 3'b010, 32'h044, 32'h5555AAAA, 5'd10, 0, 32'h01020304);
        run_mem(1'b1, 1'b0, 3'b010, 32'h080, 32'h0, 5'd11, -1, 32'h0);
        chk("lit_to_cause", 32'(fault_cause), 32'h3);
        chk("lit_to_addr", fault_addr, 32'h080);

        // Non-memory instruction: no action
        ex_valid = 1'b1;
        quiet();
        step();
        ex_valid = 1'b0;
        step();

        // Reset during WAIT after two cycles
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h300; ex_rd = 5'd12;
        quiet();
        exp_stall = 1'b1;
        step();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_wait(1'b1, 3'b010, 32'h300, 32'h0);
            step();
        end
        set_wait(1'b1, 3'b010, 32'h300, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        quiet();
        exp_fault_cause = '0;
        exp_fault_addr  = '0;
        step();
        run_mem(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd12, 3, 32'h76543210);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
